// File: rtl/vga_score_render.sv
// vga_score_render: multi-player seven-segment score renderer with a per-frame
// double-dabble BCD engine, leading-zero blanking, saturation and leader blinking.
module vga_score_render #(
    parameter int          NUM_PLAYERS  = 2,
    parameter int          NUM_DIGITS   = 2,
    parameter int          SCORE_W      = 8,
    parameter int          SEG_T        = 10,
    parameter int          SEG_L        = 30,
    parameter int          DIG_GAP      = 10,
    parameter int          X0           = 100,
    parameter int          Y0           = 190,
    parameter int          PLAYER_DX    = 240,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] FG_COLOR     = 12'hfff,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter logic [11:0] HL_COLOR     = 12'hf00
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     h_cnt,
    input  logic [9:0]                     v_cnt,
    input  logic                           valid,
    input  logic                           vsync,
    input  logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    input  logic                           blink_en,
    output logic                           busy,
    output logic [3:0]                     vgaRed,
    output logic [3:0]                     vgaGreen,
    output logic [3:0]                     vgaBlue
);
    localparam int DIG_W = 2*SEG_T + SEG_L;
    localparam int DIG_H = 3*SEG_T + 2*SEG_L;
    localparam int BW    = 4*NUM_DIGITS;
    localparam int PW    = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1;
    localparam int CW    = $clog2(SCORE_W + 1);
    localparam int FW    = $clog2(BLINK_FRAMES + 1);
    localparam logic [31:0]   MAX_SCORE = 32'(10**NUM_DIGITS - 1);
    localparam logic [FW-1:0] BF_LAST   = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;
    state_t state, state_n;

    logic                vsync_q, trig, last_bit, last_plr, lead_ok, has_lead, phase;
    logic [PW-1:0]       plr, lead, lead_n;
    logic [CW-1:0]       bit_idx;
    logic [FW-1:0]       blink_cnt;
    logic [SCORE_W-1:0]  sh;
    logic [SCORE_W-1:0]  sat [NUM_PLAYERS];
    logic [SCORE_W-1:0]  snap [NUM_PLAYERS];
    logic [BW-1:0]       work [NUM_PLAYERS];
    logic [BW-1:0]       shadow [NUM_PLAYERS];
    logic [BW-1:0]       adj;
    logic [11:0]         pix;

    function automatic logic [6:0] seven(input logic [3:0] d);
        case (d)
            4'd0: seven = 7'b1111110;
            4'd1: seven = 7'b0110000;
            4'd2: seven = 7'b1101101;
            4'd3: seven = 7'b1111001;
            4'd4: seven = 7'b0110011;
            4'd5: seven = 7'b1011011;
            4'd6: seven = 7'b1011111;
            4'd7: seven = 7'b1110000;
            4'd8: seven = 7'b1111111;
            4'd9: seven = 7'b1111011;
            default: seven = 7'b0000000;
        endcase
    endfunction

    // Mask bit 6 is segment a, bit 0 is segment g; corners fall in no region.
    function automatic logic seg_hit(input int x, input int y, input logic [6:0] m);
        logic xl, xa, xr, yt, yu, ym, yl, yb;
        xl = x >= 0 && x < SEG_T;
        xa = x >= SEG_T && x < SEG_T + SEG_L;
        xr = x >= SEG_T + SEG_L && x < DIG_W;
        yt = y >= 0 && y < SEG_T;
        yu = y >= SEG_T && y < SEG_T + SEG_L;
        ym = y >= SEG_T + SEG_L && y < 2*SEG_T + SEG_L;
        yl = y >= 2*SEG_T + SEG_L && y < 2*SEG_T + 2*SEG_L;
        yb = y >= 2*SEG_T + 2*SEG_L && y < DIG_H;
        seg_hit = (m[6] && xa && yt) || (m[5] && xr && yu) || (m[4] && xr && yl) ||
                  (m[3] && xa && yb) || (m[2] && xl && yl) || (m[1] && xl && yu) ||
                  (m[0] && xa && ym);
    endfunction

    assign trig     = vsync_q & ~vsync;
    assign busy     = state != IDLE;
    assign last_bit = bit_idx == CW'(SCORE_W - 1);
    assign last_plr = plr == PW'(NUM_PLAYERS - 1);

    always_comb begin
        logic gt;
        lead_ok = 1'b0;
        lead_n  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            sat[p] = 32'(scores[p*SCORE_W +: SCORE_W]) > MAX_SCORE ? MAX_SCORE[SCORE_W-1:0] : scores[p*SCORE_W +: SCORE_W];
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            gt = 1'b1;
            for (int q = 0; q < NUM_PLAYERS; q++)
                if (q != p && sat[q] >= sat[p]) gt = 1'b0;
            if (gt) begin
                lead_ok = 1'b1;
                lead_n  = PW'(p);
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = trig ? LOAD : IDLE;
            LOAD:    state_n = SHIFT;
            SHIFT:   state_n = !last_bit ? SHIFT : last_plr ? COMMIT : LOAD;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        adj = work[plr];
        for (int n = 0; n < NUM_DIGITS; n++)
            adj[4*n +: 4] = work[plr][4*n +: 4] >= 4'd5 ? work[plr][4*n +: 4] + 4'd3 : work[plr][4*n +: 4];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q   <= 1'b1;
            plr       <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            has_lead  <= 1'b0;
            lead      <= '0;
            {vgaRed, vgaGreen, vgaBlue} <= 12'h000;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                snap[p]   <= '0;
                work[p]   <= '0;
                shadow[p] <= '0;
            end
        end else begin
            vsync_q <= vsync;
            {vgaRed, vgaGreen, vgaBlue} <= pix;
            if (state == IDLE && trig) begin
                for (int p = 0; p < NUM_PLAYERS; p++) snap[p] <= sat[p];
                has_lead  <= lead_ok;
                lead      <= lead_n;
                plr       <= '0;
                blink_cnt <= blink_cnt == BF_LAST ? '0 : blink_cnt + 1'b1;
                phase     <= phase ^ (blink_cnt == BF_LAST);
            end
            if (state == LOAD) begin
                work[plr] <= '0;
                sh        <= snap[plr];
                bit_idx   <= '0;
            end
            if (state == SHIFT) begin
                {work[plr], sh} <= {adj, sh} << 1;
                bit_idx <= bit_idx + 1'b1;
                if (last_bit) plr <= plr + 1'b1;
            end
            if (state == COMMIT)
                for (int p = 0; p < NUM_PLAYERS; p++) shadow[p] <= work[p];
        end
    end

    always_comb begin
        logic       lit, lit_lead, blank, on;
        logic [3:0] dig;
        int         lx, ly;
        lit      = 1'b0;
        lit_lead = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            blank = 1'b1;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                dig   = shadow[p][4*(NUM_DIGITS-1-k) +: 4];
                blank = blank && dig == 4'd0 && k != NUM_DIGITS - 1;
                lx    = int'(h_cnt) - (X0 + p*PLAYER_DX + k*(DIG_W + DIG_GAP));
                ly    = int'(v_cnt) - Y0;
                on    = !blank && seg_hit(lx, ly, seven(dig));
                lit   = lit | on;
                if (on && has_lead && lead == PW'(p)) lit_lead = 1'b1;
            end
        end
        pix = !valid ? 12'h000 : !lit ? BG_COLOR : (lit_lead && blink_en && phase) ? HL_COLOR : FG_COLOR;
    end
endmodule

// File: tb/tb_vga_score_render.sv
// tb_vga_score_render: directed stimulus with a decimal-arithmetic pixel model
// checked every cycle, plus hand-computed pixel literals.
module tb_vga_score_render;
    localparam int T = 10, L = 30, DW = 2*T + L, DH = 3*T + 2*L;
    localparam int X0 = 100, Y0 = 190, DX = 240, GAP = 10, BF = 30, CONV = 19;
    localparam logic [11:0] FG = 12'hfff, BG = 12'h000, HL = 12'hf00;
    localparam logic [6:0] MASK [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                         7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    localparam int RX0 [7] = '{T, T+L, T+L, T, 0, 0, T};
    localparam int RX1 [7] = '{T+L, DW, DW, T+L, T, T, T+L};
    localparam int RY0 [7] = '{0, T, 2*T+L, 2*T+2*L, 2*T+L, T, T+L};
    localparam int RY1 [7] = '{T, T+L, 2*T+2*L, DH, 2*T+2*L, T+L, 2*T+L};

    logic        clk = 1'b0, rst, valid, vsync, blink_en, busy;
    logic [9:0]  h_cnt, v_cnt;
    logic [15:0] scores;
    logic [3:0]  vgaRed, vgaGreen, vgaBlue;
    int          total = 0, bad = 0, n;

    int          m_shadow [2], m_snap [2];
    int          m_cnt, m_trigs, m_lead;
    bit          m_vq;
    logic [11:0] exp_pix;

    vga_score_render dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .vsync(vsync),
        .scores(scores), .blink_en(blink_en), .busy(busy),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int s);
        return s > 99 ? 99 : s;
    endfunction

    function automatic int leader(input int a, input int b);
        return a > b ? 0 : b > a ? 1 : -1;
    endfunction

    function automatic logic [11:0] model_pix(input int x, input int y, input bit vld);
        bit lit;
        int lp, lx, ly, val, div, d;
        logic [6:0] m;
        lit = 0;
        lp  = -1;
        if (!vld) return 12'h000;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 2; k++) begin
                lx  = x - (X0 + p*DX + k*(DW + GAP));
                ly  = y - Y0;
                val = m_shadow[p];
                div = k == 0 ? 10 : 1;
                if (lx >= 0 && lx < DW && ly >= 0 && ly < DH && !(k == 0 && val < 10)) begin
                    d = (val / div) % 10;
                    m = MASK[d];
                    for (int s = 0; s < 7; s++)
                        if (m[6-s] && lx >= RX0[s] && lx < RX1[s] && ly >= RY0[s] && ly < RY1[s]) begin
                            lit = 1;
                            lp  = p;
                        end
                end
            end
        if (!lit) return BG;
        return (lp == m_lead && blink_en && ((m_trigs / BF) % 2 == 1)) ? HL : FG;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_vq <= 1; m_cnt <= 0; m_trigs <= 0; m_lead <= -1;
            m_shadow <= '{0, 0}; m_snap <= '{0, 0}; exp_pix <= 12'h000;
        end else begin
            exp_pix <= model_pix(int'(h_cnt), int'(v_cnt), valid);
            m_vq    <= vsync;
            if (m_vq && !vsync && m_cnt == 0) begin
                m_snap[0] <= sat(int'(scores[7:0]));
                m_snap[1] <= sat(int'(scores[15:8]));
                m_lead    <= leader(sat(int'(scores[7:0])), sat(int'(scores[15:8])));
                m_cnt     <= CONV;
                m_trigs   <= m_trigs + 1;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_shadow <= m_snap;
            end
        end
    end

    always @(negedge clk)
        if (!rst) begin
            total++;
            if ({vgaRed, vgaGreen, vgaBlue} !== exp_pix) begin
                bad++;
                $display("FAIL model_pix t=%0t h=%0d v=%0d got=%h want=%h", $time, h_cnt, v_cnt, {vgaRed, vgaGreen, vgaBlue}, exp_pix);
            end
            total++;
            if (busy !== (m_cnt != 0)) begin
                bad++;
                $display("FAIL model_busy t=%0t got=%b want=%b", $time, busy, m_cnt != 0);
            end
        end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic probe(input string name, input int x, input int y, input logic [11:0] want);
        h_cnt = 10'(x);
        v_cnt = 10'(y);
        @(posedge clk); #1;
        chk(name, int'({vgaRed, vgaGreen, vgaBlue}), int'(want));
    endtask

    task automatic frame(output int cyc);
        vsync = 0;
        @(posedge clk); #1;
        vsync = 1;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1; valid = 1; vsync = 1; blink_en = 0; scores = '0; h_cnt = '0; v_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_rgb", int'({vgaRed, vgaGreen, vgaBlue}), 0);
        rst = 0;
        probe("reset_zero_a", 175, 195, FG);
        probe("reset_blank", 115, 195, BG);

        scores = {8'd0, 8'd57};
        frame(n);
        chk("busy_len", n, CONV);
        probe("five_a", 115, 195, FG);
        probe("five_b_off", 145, 205, BG);
        probe("seven_a", 175, 195, FG);
        probe("corner", 105, 195, BG);
        probe("five_g", 115, 235, FG);

        scores = {8'd0, 8'd7};
        frame(n);
        chk("busy_len7", n, CONV);
        probe("blank_d0", 115, 195, BG);
        probe("seven_a2", 175, 195, FG);
        probe("seven_b_edge", 209, 205, FG);
        probe("gap_edge", 210, 205, BG);
        probe("p1_zero_a", 415, 195, FG);
        probe("p1_blank", 355, 195, BG);
        probe("p1_zero_g_off", 415, 235, BG);

        scores = {8'd0, 8'd255};
        frame(n);
        probe("sat_nine_g", 115, 235, FG);
        probe("sat_nine_g1", 175, 235, FG);
        scores = {8'd0, 8'd100};
        frame(n);
        probe("sat100_g", 115, 235, FG);

        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        blink_en = 1;
        scores = {8'd5, 8'd12};
        vsync = 0;
        @(posedge clk); #1;
        vsync = 1;
        scores[7:0] = 8'd34;
        repeat (3) @(posedge clk);
        #1;
        vsync = 0;
        @(posedge clk); #1;
        vsync = 1;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("ign_done", int'(busy), 0);
        probe("hold_one_a", 115, 195, BG);
        probe("hold_one_b", 145, 205, FG);
        probe("hold_two_a", 175, 195, FG);
        probe("hold_two_c", 205, 265, BG);
        scores[7:0] = 8'd12;
        for (int i = 0; i < 28; i++) frame(n);
        probe("phase0_lead", 145, 205, FG);
        frame(n);
        probe("phase1_lead", 145, 205, HL);
        probe("phase1_other", 415, 195, FG);
        scores = {8'd12, 8'd12};
        frame(n);
        probe("tie_no_hl", 145, 205, FG);

        valid = 0;
        probe("valid_low", 145, 205, 12'h000);
        valid = 1;

        vsync = 0;
        @(posedge clk); #1;
        vsync = 1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_rgb", int'({vgaRed, vgaGreen, vgaBlue}), 0);
        @(posedge clk); #1;
        rst = 0;
        probe("rst_p0_zero", 175, 195, FG);
        probe("rst_p0_blank", 145, 205, BG);
        probe("rst_p1_zero", 415, 195, FG);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
